// File: rtl/pattern_scan_ctrl.sv
// Word-to-serial sequencing controller for an overlapping 4-bit pattern detector.
// Words are accepted in IDLE, shifted out MSB-first, then a one-cycle DONE pulse.
module pattern_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              cfg_load,
    input  logic [3:0]        cfg_pattern,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [CNT_W-1:0]  match_count
);

    localparam int IDX_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  sreg;
    logic [IDX_W-1:0]   bit_idx;
    logic [2:0]         hist;
    logic [1:0]         fill;
    logic [3:0]         pattern;
    logic               bit_in;
    logic               match_now;

    assign bit_in    = sreg[WORD_W-1];
    assign match_now = (fill == 2'd3) && ({hist, bit_in} == pattern);

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            sreg        <= '0;
            bit_idx     <= '0;
            hist        <= '0;
            fill        <= '0;
            pattern     <= 4'b1101;
            match       <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
        end else if (clear) begin
            // pattern is deliberately kept across a flush
            state       <= ST_IDLE;
            bit_idx     <= '0;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
        end else begin
            match <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_load) begin
                        pattern <= cfg_pattern;
                        hist    <= '0;
                        fill    <= '0;
                    end
                    if (in_valid) begin
                        sreg    <= in_data;
                        bit_idx <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sreg <= {sreg[WORD_W-2:0], 1'b0};
                    hist <= {hist[1:0], bit_in};
                    if (fill != 2'd3) fill <= fill + 2'd1;
                    if (match_now) begin
                        match <= 1'b1;
                        if (match_count != '1) match_count <= match_count + CNT_W'(1);
                    end
                    if (bit_idx == IDX_W'(WORD_W - 1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: a behavioural detector model feeds a
// per-cycle expectation queue that is compared as each bit is consumed.
module tb_pattern_scan_ctrl;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              clear;
    logic              cfg_load;
    logic [3:0]        cfg_pattern;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              busy;
    logic              done;
    logic              match;
    logic [CNT_W-1:0]  match_count;

    pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .done(done), .match(match),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             m;
        logic [CNT_W-1:0] c;
        logic             d;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // reference detector state
    logic [2:0]       m_hist;
    logic [1:0]       m_fill;
    logic [3:0]       m_pat;
    logic [CNT_W-1:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_bit(input logic b, output logic mt);
        mt = (m_fill == 2'd3) && ({m_hist, b} == m_pat);
        m_hist = {m_hist[1:0], b};
        if (m_fill != 2'd3) m_fill = m_fill + 2'd1;
        if (mt && m_cnt != '1) m_cnt = m_cnt + CNT_W'(1);
    endtask

    task automatic model_flush();
        m_hist = '0;
        m_fill = '0;
        m_cnt  = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},   32'(in_ready),    32'd1);
        chk({tag, "_busy"},  32'(busy),        32'd0);
        chk({tag, "_done"},  32'(done),        32'd0);
        chk({tag, "_match"}, 32'(match),       32'd0);
        chk({tag, "_cnt"},   32'(match_count), 32'd0);
    endtask

    task automatic do_clear();
        @(negedge clk) clear = 1'b1;
        @(posedge clk);
        @(negedge clk) clear = 1'b0;
        model_flush();
    endtask

    task automatic do_cfg(input logic [3:0] p);
        @(negedge clk) begin cfg_load = 1'b1; cfg_pattern = p; end
        @(posedge clk);
        @(negedge clk) cfg_load = 1'b0;
        m_pat = p; m_hist = '0; m_fill = '0;
    endtask

    // disturb drives in_valid/cfg_load throughout SHIFT, which must be ignored
    task automatic send_word(input string tag, input logic [WORD_W-1:0] w,
                             input bit disturb, output logic [WORD_W-1:0] mask);
        logic mt;
        exp_t e;
        mask = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            model_bit(w[i], mt);
            q.push_back('{m: mt, c: m_cnt, d: (i == 0)});
        end
        @(negedge clk);
        for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
        chk({tag, "_rdy_wait"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = w;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_busy_e0"}, {30'd0, busy, in_ready}, 32'b10);
        for (int k = 1; k <= WORD_W; k++) begin
            in_valid = disturb; cfg_load = disturb;
            cfg_pattern = 4'b1101; in_data = '1;
            @(posedge clk);
            @(negedge clk);
            e = q.pop_front();
            chk({tag, "_match"}, 32'(match),       32'(e.m));
            chk({tag, "_cnt"},   32'(match_count), 32'(e.c));
            chk({tag, "_done"},  32'(done),        32'(e.d));
            mask[k-1] = match;
        end
        in_valid = 1'b0; cfg_load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle_after"}, {29'd0, in_ready, busy, done}, 32'b100);
    endtask

    logic [WORD_W-1:0] msk;
    int saw_done;

    initial begin
        n_rst = 1'b0; clear = 1'b0; cfg_load = 1'b0; cfg_pattern = '0;
        in_valid = 1'b0; in_data = '0;
        m_pat = 4'b1101; model_flush();
        #1 chk_reset_vals("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk) n_rst = 1'b1;
        @(negedge clk) chk_reset_vals("rst_rel");

        // default pattern 1101: matches after E4 and E7
        send_word("w11011011", 8'b11011011, 1'b0, msk);
        chk("w1_mask", 32'(msk), 32'h48);
        chk("w1_cnt", 32'(match_count), 32'd2);

        // pattern spanning a word boundary
        do_clear();
        chk("clr_cnt", 32'(match_count), 32'd0);
        send_word("xw1", 8'b00000110, 1'b0, msk);
        chk("xw1_mask", 32'(msk), 32'h00);
        send_word("xw2", 8'b10000000, 1'b0, msk);
        chk("xw2_mask", 32'(msk), 32'h01);
        chk("xw2_cnt", 32'(match_count), 32'd1);

        // pattern 0000, then saturation
        do_clear();
        do_cfg(4'b0000);
        send_word("z1", 8'h00, 1'b0, msk);
        chk("z1_mask", 32'(msk), 32'hF8);
        chk("z1_cnt", 32'(match_count), 32'd5);
        send_word("z2", 8'h00, 1'b0, msk);
        chk("z2_cnt", 32'(match_count), 32'd13);
        send_word("z3", 8'h00, 1'b0, msk);
        chk("z3_cnt", 32'(match_count), 32'd15);
        send_word("z4", 8'h00, 1'b0, msk);
        chk("z4_mask", 32'(msk), 32'hFF);
        chk("z4_cnt", 32'(match_count), 32'd15);

        // clear during the third SHIFT cycle
        @(negedge clk) begin in_valid = 1'b1; in_data = 8'h00; end
        @(posedge clk);
        @(negedge clk) in_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk) clear = 1'b0;
        model_flush();
        chk_reset_vals("midclr");
        saw_done = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        chk("midclr_no_done", 32'(saw_done), 32'd0);

        // in_valid/cfg_load during SHIFT ignored: pattern stays 0000
        send_word("dist", 8'h00, 1'b1, msk);
        chk("dist_mask", 32'(msk), 32'hF8);
        chk("dist_cnt", 32'(match_count), 32'd5);

        // async reset mid-SHIFT
        @(negedge clk) begin in_valid = 1'b1; in_data = 8'h00; end
        @(posedge clk);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_match", 32'(match), 32'd1);
        chk("pre_rst_cnt", 32'(match_count), 32'd6);
        @(posedge clk);
        #1 n_rst = 1'b0;
        #1 chk_reset_vals("midrst");
        @(posedge clk);
        @(negedge clk) n_rst = 1'b1;
        m_pat = 4'b1101; model_flush();
        send_word("post_rst", 8'b11011011, 1'b0, msk);
        chk("post_rst_mask", 32'(msk), 32'h48);
        chk("post_rst_cnt", 32'(match_count), 32'd2);
        chk("q_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencing controller for a 4-bit serial pattern detector. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first, one bit per cycle, into a programmable overlapping 4-bit sequence detector. It counts detections and signals end of word. It sits between a word-oriented producer and the serial detection datapath, and owns detector configuration and scheduling.

## Interface
- WORD_W, 8, input word width in bits (≥4)
- CNT_W, 4, match counter width
- clk  in  1  rising-edge clock
- n_rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort/flush, any state
- cfg_load  in  1  load cfg_pattern (honoured only in IDLE)
- cfg_pattern  in  4  sequence to detect; bit 3 is the oldest bit
- in_valid  in  1  in_data valid
- in_ready  out  1  controller can accept a word
- in_data  in  WORD_W  word to scan, MSB first
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, word fully scanned
- match  out  1  one-cycle pulse, pattern completed
- match_count  out  CNT_W  saturating detection count

## Operation
- States:
  - IDLE: in_ready=1.
  - SHIFT: scan WORD_W bits.
  - DONE: one cycle, done=1, in_ready=0.
- Transitions:
  - IDLE→SHIFT on in_valid&&in_ready. in_data is latched into the shift register and bit_idx=0.
  - SHIFT consumes one bit per edge.
  - SHIFT→DONE on the edge that consumes bit 0, the LSB.
  - DONE→IDLE unconditionally.
- in_valid outside IDLE is ignored. The producer holds in_data until in_ready.
- Detector:
  - 3-bit history register hist plus a fill counter (0..3, saturating).
  - On each consumed bit b: match_now = (fill==3) && ({hist,b}==pattern). Then hist<={hist[1:0],b} and fill increments.
  - Detection is overlapping: a match does not clear hist.
  - hist and fill persist across words. A pattern may span a word boundary.
- Pattern register resets to 4'b1101.
- cfg_load in IDLE loads cfg_pattern and clears hist and fill. match_count is kept.
- cfg_load outside IDLE is ignored.
- match_count increments on each match_now and saturates at 2^CNT_W−1. It does not wrap.
- clear has priority over the handshake and over cfg_load. On the next edge:
  - state=IDLE and in_ready=1.
  - hist=0, fill=0, match_count=0.
  - Any pending match or done is suppressed.
  - The pattern register is retained.
- Reset mid-operation behaves like clear, and additionally restores pattern=1101.

## Timing
- Reset values: in_ready=1, busy=0, done=0, match=0, match_count=0, state=IDLE, pattern=1101.
- Handshake at edge E0.
- Bits WORD_W−1..0 are consumed at edges E1..E_WORD_W.
- done is high in the cycle after E_WORD_W. in_ready is high again after E_WORD_W+1.
- Word throughput is one word per WORD_W+2 cycles.
- match is registered:
  - It is high in the cycle after the edge that consumed the completing bit.
  - match_count shows the new value in that same cycle.
  - A match on the LSB coincides with done.
- busy is 1 from the cycle after E0 through the DONE cycle inclusive.
- All outputs are registered, or decoded from registered state only.

## Test plan
- Reset → in_ready=1, busy=0, done=0, match=0, match_count=0; default pattern 1101 active.
- Default pattern, word 8'b11011011 → match pulses after E4 and E7; match_count=2; done after E8.
- Cross-word: 8'b00000110, then 8'b10000000 → no match in word 1; match after E1 of word 2; match_count=1.
- cfg_load 4'b0000 in IDLE, word 8'h00 → 5 matches, after E4..E8; match_count=5; the fifth match coincides with done.
- Saturation (CNT_W=4), pattern 0000:
  - Words 8'h00, 8'h00, 8'h00 → the count reaches 15 and holds at 15.
  - A further 8'h00 word still pulses match and the count stays 15.
- Mid-operation events:
  - clear asserted at the third SHIFT cycle → IDLE next cycle, match_count=0, no done.
  - in_valid and cfg_load during SHIFT → ignored; pattern unchanged.
  - n_rst pulse mid-SHIFT → all outputs at their reset values immediately.
